// File: rtl/wc_tile_feeder.sv
// Sliding 6-sample window feeding overlapped tiles (stride 3) to a Winograd core.
// A tile is captured into an output register and held until downstream consumes it.
module wc_tile_feeder #(
   parameter int DW = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DW-1:0]     in_data,
   input  logic              in_sof,
   output logic              in_ready,
   output logic [6*DW-1:0]   D,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        tile_idx
);

   localparam logic ST_FILL   = 1'b0;
   localparam logic ST_STRIDE = 1'b1;

   logic [6*DW-1:0] win_q, win_d;
   logic [6*DW-1:0] tile_q, tile_d;
   logic [2:0]      fill_q, fill_d;
   logic [1:0]      stride_q, stride_d;
   logic            state_q, state_d;
   logic [7:0]      next_idx_q, next_idx_d;
   logic [7:0]      idx_q, idx_d;
   logic            valid_q, valid_d;
   logic            accept_s;
   logic            complete_s;

   assign in_ready  = !valid_q || out_ready;
   assign accept_s  = in_valid && in_ready;
   assign D         = tile_q;
   assign out_valid = valid_q;
   assign tile_idx  = idx_q;

   // Window shift, fill/stride bookkeeping and tile capture
   always_comb begin
      win_d      = win_q;
      tile_d     = tile_q;
      fill_d     = fill_q;
      stride_d   = stride_q;
      state_d    = state_q;
      next_idx_d = next_idx_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      complete_s = 1'b0;

      if (accept_s) begin
         win_d = {win_q[5*DW-1:0], in_data};
         if (in_sof) begin
            // A new frame restarts counting from this very sample
            fill_d     = 3'd1;
            stride_d   = 2'd0;
            state_d    = ST_FILL;
            next_idx_d = 8'd0;
         end else begin
            case (state_q)
               ST_FILL: begin
                  fill_d = fill_q + 3'd1;
                  if (fill_q == 3'd5) begin
                     state_d    = ST_STRIDE;
                     stride_d   = 2'd0;
                     complete_s = 1'b1;
                  end else begin
                     state_d = ST_FILL;
                  end
               end
               ST_STRIDE: begin
                  if (stride_q == 2'd2) begin
                     stride_d   = 2'd0;
                     complete_s = 1'b1;
                  end else begin
                     stride_d = stride_q + 2'd1;
                  end
               end
               default: begin
                  state_d = ST_FILL;
               end
            endcase
         end
      end else begin
         win_d = win_q;
      end

      if (complete_s) begin
         tile_d     = win_d;
         valid_d    = 1'b1;
         idx_d      = next_idx_q;
         next_idx_d = next_idx_q + 8'd1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q      <= '0;
         tile_q     <= '0;
         fill_q     <= 3'd0;
         stride_q   <= 2'd0;
         state_q    <= ST_FILL;
         next_idx_q <= 8'd0;
         idx_q      <= 8'd0;
         valid_q    <= 1'b0;
      end else begin
         win_q      <= win_d;
         tile_q     <= tile_d;
         fill_q     <= fill_d;
         stride_q   <= stride_d;
         state_q    <= state_d;
         next_idx_q <= next_idx_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
      end
   end

endmodule
